// File: rtl/fw_wb_pkg.sv
// Shared Wishbone watchdog encodings: FSM states and response types.
package fw_wb_pkg;

   localparam int unsigned TO_COUNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RSP_ACK     = 2'd0,
      RSP_ERR     = 2'd1,
      RSP_TIMEOUT = 2'd2
   } rsp_t;

   // A target error outranks a simultaneous target ack.
   function automatic rsp_t rsp_select(input logic tack, input logic terr);
      if (terr) return RSP_ERR;
      if (tack) return RSP_ACK;
      return RSP_TIMEOUT;
   endfunction

endpackage

// File: rtl/wb_watchdog_timer.sv
// Saturating REQ-state cycle counter; expired flags the last allowed cycle.
module wb_watchdog_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] r_count;
   logic          r_expired;

   // Counter holds at LAST so it can never wrap; flag tracks count==LAST.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         r_count   <= '0;
         r_expired <= 1'b0;
      end else if (run && (r_count != LAST)) begin
         r_count   <= r_count + TW'(1);
         r_expired <= (r_count == (LAST - TW'(1)));
      end
   end

   assign expired = r_expired;

endmodule

// File: rtl/wb_target_watchdog.sv
// Wishbone target-side watchdog: forwards one transfer, returns err on timeout.
// Optional status outputs enabled by WB_TARGET_WATCHDOG_STATUS_EN.
module wb_target_watchdog
   import fw_wb_pkg::*;
#(
   parameter int unsigned WB_ADDR_WIDTH  = 32,
   parameter int unsigned WB_DATA_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WB_ADDR_WIDTH-1:0]   adr,
   input  logic [WB_DATA_WIDTH-1:0]   dat_w,
   input  logic [WB_DATA_WIDTH/8-1:0] sel,
   input  logic                       cyc,
   input  logic                       stb,
   input  logic                       we,
   output logic [WB_DATA_WIDTH-1:0]   dat_r,
   output logic                       ack,
   output logic                       err,
   output logic [WB_ADDR_WIDTH-1:0]   tadr,
   output logic [WB_DATA_WIDTH-1:0]   tdat_w,
   output logic [WB_DATA_WIDTH/8-1:0] tsel,
   output logic                       tcyc,
   output logic                       tstb,
   output logic                       twe,
`ifdef WB_TARGET_WATCHDOG_STATUS_EN
   output logic [TO_COUNT_W-1:0]      to_count,
   output logic [WB_ADDR_WIDTH-1:0]   to_adr,
   output logic                       to_irq,
`endif
   input  logic [WB_DATA_WIDTH-1:0]   tdat_r,
   input  logic                       tack,
   input  logic                       terr
);

   localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;

   state_t                   r_state;
   logic [WB_ADDR_WIDTH-1:0] r_tadr;
   logic [WB_DATA_WIDTH-1:0] r_tdat_w;
   logic [SEL_W-1:0]         r_tsel;
   logic                     r_twe;
   logic                     r_tcyc;
   logic                     r_tstb;
   logic [WB_DATA_WIDTH-1:0] r_dat_r;
   logic                     r_ack;
   logic                     r_err;

   logic w_resp;
   logic w_expired;
   logic w_clear;
   logic w_run;
   rsp_t w_rsp;

   assign w_resp  = tack | terr;
   assign w_clear = (r_state != ST_REQ);
   assign w_run   = (r_state == ST_REQ) && !w_resp;
   assign w_rsp   = w_resp ? rsp_select(tack, terr) : RSP_TIMEOUT;

   wb_watchdog_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (w_clear),
      .run    (w_run),
      .expired(w_expired)
   );

   // Transfer FSM; ack/err are set on entry to RESP so they are high exactly in RESP.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_tadr   <= '0;
         r_tdat_w <= '0;
         r_tsel   <= '0;
         r_twe    <= 1'b0;
         r_tcyc   <= 1'b0;
         r_tstb   <= 1'b0;
         r_dat_r  <= '0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cyc && stb) begin
                  r_tadr   <= adr;
                  r_tdat_w <= dat_w;
                  r_tsel   <= sel;
                  r_twe    <= we;
                  r_tcyc   <= 1'b1;
                  r_tstb   <= 1'b1;
                  r_state  <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!cyc) begin
                  r_tcyc  <= 1'b0;
                  r_tstb  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_resp || w_expired) begin
                  r_tcyc  <= 1'b0;
                  r_tstb  <= 1'b0;
                  r_dat_r <= w_resp ? tdat_r : '0;
                  r_ack   <= (w_rsp == RSP_ACK);
                  r_err   <= (w_rsp != RSP_ACK);
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tadr   = r_tadr;
   assign tdat_w = r_tdat_w;
   assign tsel   = r_tsel;
   assign twe    = r_twe;
   assign tcyc   = r_tcyc;
   assign tstb   = r_tstb;
   assign dat_r  = r_dat_r;
   assign ack    = r_ack;
   assign err    = r_err;

`ifdef WB_TARGET_WATCHDOG_STATUS_EN
   logic                     w_timeout;
   logic [TO_COUNT_W-1:0]    r_to_count;
   logic [WB_ADDR_WIDTH-1:0] r_to_adr;
   logic                     r_to_irq;

   assign w_timeout = (r_state == ST_REQ) && cyc && !w_resp && w_expired;

   // Timeout statistics; irq lines up with the timeout err pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_to_count <= '0;
         r_to_adr   <= '0;
         r_to_irq   <= 1'b0;
      end else begin
         r_to_irq <= w_timeout;
         if (w_timeout) begin
            r_to_adr <= r_tadr;
            if (r_to_count != {TO_COUNT_W{1'b1}}) r_to_count <= r_to_count + TO_COUNT_W'(1);
         end
      end
   end

   assign to_count = r_to_count;
   assign to_adr   = r_to_adr;
   assign to_irq   = r_to_irq;
`endif

endmodule
